dmem_resp: RTL and testbench

//  Multi-cycle data-memory responder that serves the cpu MEM stage: memRead/memWrite, address, writeData.

---
 rtl/dmem_resp.sv | 108 ++++++++++
 tb/tb_dmem_resp.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder for the cpu MEM stage: a word-addressed RAM
// with a fixed access latency, a stall handshake and a saturating stall counter.
module dmem_resp #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        stall,
  output logic        ack,
  output logic        err,
  output logic [15:0] stall_cycles
);

  logic [15:0]       mem [2**ADDR_W];
  logic              req;
  logic [ADDR_W-1:0] acc_addr;
  logic [15:0]       acc_wdata;
  logic              acc_write;
  logic              acc_err;
  logic              unused_addr;

  assign req         = re | we;
  assign unused_addr = ^addr;

  // Both latency flavours funnel into one access port: acc_* describe the
  // access completing in the cycle ack is high.
  generate
    if (LATENCY == 0) begin : g_comb
      assign stall     = 1'b0;
      assign ack       = !rst && req;
      assign acc_addr  = addr[ADDR_W-1:0];
      assign acc_wdata = wdata;
      assign acc_write = we;
      assign acc_err   = re && we;
    end else begin : g_fsm
      typedef enum logic {IDLE, BUSY} state_t;
      state_t            state, state_n;
      logic [3:0]        cnt;
      logic [ADDR_W-1:0] addr_q;
      logic [15:0]       wdata_q;
      logic              op_q;
      logic              err_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= state_n;
          if (state == IDLE && req) begin
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            op_q    <= we;
            err_q   <= re && we;
            cnt     <= 4'(LATENCY - 1);
          end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 4'd1;
          end
        end
      end

      always_comb begin
        state_n = state;
        stall   = 1'b0;
        ack     = 1'b0;
        if (!rst) begin
          case (state)
            IDLE: if (req) begin
              stall   = 1'b1;
              state_n = BUSY;
            end
            BUSY: if (cnt != '0) begin
              stall = 1'b1;
            end else begin
              ack     = 1'b1;
              state_n = IDLE;
            end
            default: state_n = IDLE;
          endcase
        end
      end

      assign acc_addr  = addr_q;
      assign acc_wdata = wdata_q;
      assign acc_write = op_q;
      assign acc_err   = err_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (ack && acc_write) mem[acc_addr] <= acc_wdata;
  end

  assign rdata = (ack && !acc_write) ? mem[acc_addr] : '0;
  assign err   = ack && acc_err;

  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a LATENCY=2 instance for the multi-cycle path
// and a LATENCY=0 instance for the single-cycle path, sharing clock and reset.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [15:0] addr, wdata;
  logic [15:0] rdata, stall_cycles;
  logic        stall, ack, err;
  logic        re_b, we_b;
  logic [15:0] addr_b, wdata_b;
  logic [15:0] rdata_b, stall_cycles_b;
  logic        stall_b, ack_b, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_resp #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .ack(ack), .err(err), .stall_cycles(stall_cycles)
  );

  dmem_resp #(.ADDR_W(8), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .re(re_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .stall(stall_b), .ack(ack_b), .err(err_b), .stall_cycles(stall_cycles_b)
  );

  // Drives one request on the LATENCY=2 instance and reports what it saw;
  // callers do the comparisons. Returns with inputs idle, one cycle after ack.
  task automatic run_access(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, output logic [15:0] rd,
                            output logic e, output int stall_n, output logic got);
    logic gap;
    re = r; we = w; addr = a; wdata = d;
    stall_n = 0; got = 1'b0; gap = 1'b0; rd = 'x; e = 1'bx;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (ack) begin
        got = 1'b1; rd = rdata; e = err;
        if (stall) gap = 1'b1;
      end else begin
        if (stall) stall_n++; else gap = 1'b1;
        @(posedge clk);
      end
    end
    if (gap) stall_n = -1;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; re = 1'b1; we = 1'b1; addr = 16'h0001; wdata = 16'hFFFF;
    re_b = 1'b1; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ack); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    n_cmp++; if (stall_cycles !== 16'h0000) begin n_bad++; $display("FAIL reset_stall_cycles got %h want 0000", stall_cycles); end
    n_cmp++; if (ack_b !== 1'b0) begin n_bad++; $display("FAIL reset_ack_b got %b want 0", ack_b); end
    re = 1'b0; we = 1'b0; re_b = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall got %b want 0", stall); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic e, got; int sn;
    run_access(1'b0, 1'b1, 16'h0005, 16'h1234, rd, e, sn, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL wr_ack got %b want 1", got); end
    n_cmp++; if (sn !== 2) begin n_bad++; $display("FAIL wr_stall_len got %0d want 2", sn); end
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL wr_rdata got %h want 0000", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b want 0", e); end
    run_access(1'b1, 1'b0, 16'h0005, 16'h0000, rd, e, sn, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rd_ack got %b want 1", got); end
    n_cmp++; if (sn !== 2) begin n_bad++; $display("FAIL rd_stall_len got %0d want 2", sn); end
    n_cmp++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL rd_rdata got %h want 1234", rd); end
    n_cmp++; if (stall_cycles !== 16'd4) begin n_bad++; $display("FAIL stall_cycles got %0d want 4", stall_cycles); end
    n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL rdata_idle got %h want 0000", rdata); end
  endtask

  task automatic test_both_set();
    logic [15:0] rd; logic e, got; int sn;
    run_access(1'b1, 1'b1, 16'h0003, 16'hBEEF, rd, e, sn, got);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL both_err got %b want 1", e); end
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL both_rdata got %h want 0000", rd); end
    run_access(1'b1, 1'b0, 16'h0003, 16'h0000, rd, e, sn, got);
    n_cmp++; if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL both_readback got %h want beef", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL both_readback_err got %b want 0", e); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] rd; logic e, got; int sn;
    run_access(1'b0, 1'b1, 16'h0007, 16'h1111, rd, e, sn, got);
    we = 1'b1; addr = 16'h0007; wdata = 16'h5555;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL abort_t0_stall got %b want 1", stall); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL abort_t1_ack got %b want 0", ack); end
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0;
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL abort_post_ack got %b want 0", ack); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL abort_post_stall got %b want 0", stall); end
    n_cmp++; if (stall_cycles !== 16'h0000) begin n_bad++; $display("FAIL abort_stall_cycles got %h want 0000", stall_cycles); end
    run_access(1'b1, 1'b0, 16'h0007, 16'h0000, rd, e, sn, got);
    n_cmp++; if (rd !== 16'h1111) begin n_bad++; $display("FAIL abort_readback got %h want 1111", rd); end
    n_cmp++; if (stall_cycles !== 16'd2) begin n_bad++; $display("FAIL abort_count got %0d want 2", stall_cycles); end
  endtask

  task automatic test_alias();
    logic [15:0] rd; logic e, got; int sn;
    run_access(1'b0, 1'b1, 16'h0105, 16'hAAAA, rd, e, sn, got);
    run_access(1'b1, 1'b0, 16'h0005, 16'h0000, rd, e, sn, got);
    n_cmp++; if (rd !== 16'hAAAA) begin n_bad++; $display("FAIL alias_rdata got %h want aaaa", rd); end
  endtask

  task automatic test_zero_latency();
    @(posedge clk); #1;
    we_b = 1'b1; re_b = 1'b0; addr_b = 16'h0010; wdata_b = 16'h00FF;
    #1;
    n_cmp++; if (stall_b !== 1'b0) begin n_bad++; $display("FAIL l0_wr_stall got %b want 0", stall_b); end
    n_cmp++; if (ack_b !== 1'b1) begin n_bad++; $display("FAIL l0_wr_ack got %b want 1", ack_b); end
    n_cmp++; if (rdata_b !== 16'h0000) begin n_bad++; $display("FAIL l0_wr_rdata got %h want 0000", rdata_b); end
    @(posedge clk); #1;
    we_b = 1'b0; re_b = 1'b1;
    #1;
    n_cmp++; if (stall_b !== 1'b0) begin n_bad++; $display("FAIL l0_rd_stall got %b want 0", stall_b); end
    n_cmp++; if (ack_b !== 1'b1) begin n_bad++; $display("FAIL l0_rd_ack got %b want 1", ack_b); end
    n_cmp++; if (rdata_b !== 16'h00FF) begin n_bad++; $display("FAIL l0_rd_rdata got %h want 00ff", rdata_b); end
    n_cmp++; if (err_b !== 1'b0) begin n_bad++; $display("FAIL l0_rd_err got %b want 0", err_b); end
    @(posedge clk); #1;
    re_b = 1'b0;
    #1;
    n_cmp++; if (ack_b !== 1'b0) begin n_bad++; $display("FAIL l0_idle_ack got %b want 0", ack_b); end
    n_cmp++; if (stall_cycles_b !== 16'h0000) begin n_bad++; $display("FAIL l0_stall_cycles got %h want 0000", stall_cycles_b); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_both_set();
    test_reset_mid_op();
    test_alias();
    test_zero_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
